multi_format_packer: RTL and testbench
======================================

MULTI_FORMAT_PACKER -- requirements
Module: multi_format_packer

Interface
REQ-001 SHALL have parameter OUT_W, default 64, output word width in bits (multiple of 32, 32..256).
REQ-002 SHALL have parameter SAMPLE_W, default 12, MSB-aligned input sample width (fixed 12; other values unsupported).
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: mode  in  2  0=NV12 8b, 1=P010, 2=P012, 3=treated as P012.
REQ-005 SHALL have ports: y_valid in 1; y_data in 12 (sample); y_last in 1 (end of line); y_ready out 1.
REQ-006 SHALL have ports: uv_valid in 1; uv_data in 12; uv_last in 1; uv_ready out 1 (interleaved U,V samples).
REQ-007 SHALL have ports: out_valid out 1; out_data out OUT_W; out_keep out OUT_W/8 (byte valid); out_plane out 1 (0=Y,1=UV); out_last out 1; out_ready in 1.

Function
REQ-008 SHALL map each accepted sample to one lane: NV12 8b = s[11:4]; P010 16b = {s[11:2],6'b0}; P012 16b = {s[11:0],4'b0}.
REQ-009 SHALL pack N = OUT_W/8 (NV12) or OUT_W/16 (P010/P012) lanes per word; first sample in lowest lane.
REQ-010 SHALL keep an independent accumulator (lane count, data) and one-word hold register per plane.
REQ-011 SHALL move the accumulator to hold on acceptance of the Nth sample, or of a sample with *_last=1 (early flush); count returns to 0.
REQ-012 SHALL zero unused lanes on early flush; out_keep marks only filled bytes; out_last=1 exactly on words completed by *_last.
REQ-013 SHALL drive *_ready = !hold_valid || hold drained this cycle (combinational through out_ready allowed).
REQ-014 SHALL load the output register when !out_valid || out_ready; the granted hold transfers, hold_valid clears.
REQ-015 SHALL arbitrate round-robin: when both holds valid, grant the plane not granted at the last contested grant; uncontested hold granted immediately; Y wins first contest after reset.
REQ-016 SHALL hold out_data/out_keep/out_plane/out_last stable while out_valid && !out_ready.
REQ-017 SHALL present a completed word on out_valid 2 cycles after accepting its completing sample when output is free and uncontested.
REQ-018 SHALL sample mode into an internal register only when both accumulators count 0 and both holds empty; mode changes otherwise take effect at the next such idle cycle.
REQ-019 SHALL sustain one sample per cycle per plane and one output word per cycle with out_ready=1 continuously.

Reset
REQ-020 SHALL on rst clear counts, holds, output register: out_valid=0, out_data=0, out_keep=0, out_plane=0, out_last=0; mode register=0; arbiter pointer selects Y.
REQ-021 SHALL discard any partial word on rst asserted mid-operation; *_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-022 SHALL, with FMT_PACKER_STATS_EN defined, add ports stat_clr in 1, y_words out 32, uv_words out 32, stall_cycles out 32 (out_valid && !out_ready), wrapping counters cleared by rst or stat_clr.
REQ-023 SHALL, without FMT_PACKER_STATS_EN, omit those ports and all counter logic; behaviour otherwise identical.

Structure
REQ-024 SHALL place mode encoding enum, lane-width constants and a samples-per-word function in shared package fmt_pkg.
REQ-025 SHALL implement the per-plane accumulator+hold as sub-module plane_accumulator, instantiated twice.

Verification (OUT_W=64)
REQ-026 SHALL test NV12: Y samples 0x010,0x020..0x080 -> one word 0x0807060504030201, keep 0xFF, plane 0, last 0.
REQ-027 SHALL test P010: Y 0xFFF,0x004,0x800,0x000 -> 0x0000_8000_0040_FFC0, keep 0xFF.
REQ-028 SHALL test early flush: NV12 Y 0x100,0x200,0x300 with y_last on third -> 0x0000000000302010, keep 0x07, last 1.
REQ-029 SHALL test arbitration: both planes complete words same cycle, out_ready=1 -> Y then UV on consecutive cycles; next contest grants Y again after the UV grant alternates pointer correctly.
REQ-030 SHALL test backpressure: out_ready=0 for 20 cycles, Y streaming NV12 -> exactly 16 samples accepted then y_ready=0; release yields 2 words in order, no loss.
REQ-031 SHALL test mode change mid-word ignored until idle, and rst mid-word -> no output, out_valid=0 next cycle.

Source files
------------

// File: rtl/fmt_pkg.sv
// Shared definitions for multi_format_packer: pixel format encoding, lane widths,
// lane count per output word and the sample-to-lane mapping.
package fmt_pkg;

  typedef enum logic [1:0] {
    MODE_NV12     = 2'd0,
    MODE_P010     = 2'd1,
    MODE_P012     = 2'd2,
    MODE_P012_ALT = 2'd3
  } mode_e;

  localparam int SAMPLE_BITS = 12;
  localparam int LANE_W_NV12 = 8;
  localparam int LANE_W_P01X = 16;

  function automatic int samples_per_word(input int out_w, input mode_e m);
    return (m == MODE_NV12) ? out_w / LANE_W_NV12 : out_w / LANE_W_P01X;
  endfunction

  // NV12 result sits in bits [7:0]; 16-bit formats use the whole lane.
  function automatic logic [15:0] map_sample(input mode_e m, input logic [SAMPLE_BITS-1:0] s);
    case (m)
      MODE_NV12: map_sample = {8'h00, s[11:4]};
      MODE_P010: map_sample = {s[11:2], 6'b0};
      default:   map_sample = {s, 4'b0};
    endcase
  endfunction

endpackage

// File: rtl/plane_accumulator.sv
// One plane's lane accumulator plus a single-word hold register.
// Sample handshake: a sample transfers on a clock edge where i_valid && o_ready.
module plane_accumulator
  import fmt_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  mode_e                  i_mode,
  input  logic                   i_valid,
  input  logic [SAMPLE_BITS-1:0] i_data,
  input  logic                   i_last,
  output logic                   o_ready,
  input  logic                   i_take,
  output logic                   o_hold_valid,
  output logic [OUT_W-1:0]       o_hold_data,
  output logic [OUT_W/8-1:0]     o_hold_keep,
  output logic                   o_hold_last,
  output logic                   o_idle
);

  localparam int NB = OUT_W / 8;
  localparam int NL = OUT_W / 16;
  localparam int CW = $clog2(NB + 1);

  logic [CW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_data;
  logic [NB-1:0]    r_keep;
  logic             r_hold_valid;
  logic [OUT_W-1:0] r_hold_data;
  logic [NB-1:0]    r_hold_keep;
  logic             r_hold_last;

  logic             w_accept;
  logic             w_full;
  logic             w_complete;
  logic [15:0]      w_lane;
  logic [OUT_W-1:0] w_next_data;
  logic [NB-1:0]    w_next_keep;

  assign o_ready    = !r_hold_valid || i_take;
  assign w_accept   = i_valid && o_ready;
  assign w_lane     = map_sample(i_mode, i_data);
  assign w_full     = (int'(r_cnt) + 1) == samples_per_word(OUT_W, i_mode);
  assign w_complete = w_accept && (w_full || i_last);

  // Drop the new sample into the lane selected by the current count.
  always_comb begin
    w_next_data = r_data;
    w_next_keep = r_keep;
    if (i_mode == MODE_NV12) begin
      for (int i = 0; i < NB; i++) begin
        if (int'(r_cnt) == i) begin
          w_next_data[i*8 +: 8] = w_lane[7:0];
          w_next_keep[i]        = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < NL; j++) begin
        if (int'(r_cnt) == j) begin
          w_next_data[j*16 +: 16] = w_lane;
          w_next_keep[2*j +: 2]   = 2'b11;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_data       <= '0;
      r_keep       <= '0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_keep  <= '0;
      r_hold_last  <= 1'b0;
    end else begin
      if (i_take) r_hold_valid <= 1'b0;
      if (w_complete) begin
        // Accumulator restarts from zero so a short word has its unused lanes cleared.
        r_hold_valid <= 1'b1;
        r_hold_data  <= w_next_data;
        r_hold_keep  <= w_next_keep;
        r_hold_last  <= i_last;
        r_cnt        <= '0;
        r_data       <= '0;
        r_keep       <= '0;
      end else if (w_accept) begin
        r_cnt  <= r_cnt + CW'(1);
        r_data <= w_next_data;
        r_keep <= w_next_keep;
      end
    end
  end

  assign o_hold_valid = r_hold_valid;
  assign o_hold_data  = r_hold_data;
  assign o_hold_keep  = r_hold_keep;
  assign o_hold_last  = r_hold_last;
  assign o_idle       = (r_cnt == '0) && !r_hold_valid;

endmodule

// File: rtl/multi_format_packer.sv
// Packs Y and interleaved UV sample streams into NV12/P010/P012 output words with a
// round-robin output arbiter. Optional statistics counters: FMT_PACKER_STATS_EN.
module multi_format_packer
  import fmt_pkg::*;
#(
  parameter int OUT_W    = 64,
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                y_valid,
  input  logic [SAMPLE_W-1:0] y_data,
  input  logic                y_last,
  output logic                y_ready,
  input  logic                uv_valid,
  input  logic [SAMPLE_W-1:0] uv_data,
  input  logic                uv_last,
  output logic                uv_ready,
  output logic                out_valid,
  output logic [OUT_W-1:0]    out_data,
  output logic [OUT_W/8-1:0]  out_keep,
  output logic                out_plane,
  output logic                out_last,
  input  logic                out_ready
`ifdef FMT_PACKER_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [31:0]         y_words,
  output logic [31:0]         uv_words,
  output logic [31:0]         stall_cycles
`endif
);

  mode_e              r_mode;
  mode_e              w_mode;
  logic               w_idle;
  logic               w_y_idle, w_uv_idle;
  logic               w_y_hv, w_uv_hv;
  logic [OUT_W-1:0]   w_y_hd, w_uv_hd;
  logic [OUT_W/8-1:0] w_y_hk, w_uv_hk;
  logic               w_y_hl, w_uv_hl;
  logic               w_load, w_contest, w_grant_y, w_grant_uv;
  logic               r_ptr_uv;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic [OUT_W/8-1:0] r_out_keep;
  logic               r_out_plane;
  logic               r_out_last;

  // A new mode only applies when nothing is partially packed on either plane.
  assign w_idle = w_y_idle && w_uv_idle;
  assign w_mode = w_idle ? mode_e'(mode) : r_mode;

  always_ff @(posedge clk) begin
    if (rst) r_mode <= MODE_NV12;
    else     r_mode <= w_mode;
  end

  plane_accumulator #(.OUT_W(OUT_W)) u_y_acc (
    .clk(clk), .rst(rst), .i_mode(w_mode),
    .i_valid(y_valid), .i_data(y_data), .i_last(y_last), .o_ready(y_ready),
    .i_take(w_grant_y),
    .o_hold_valid(w_y_hv), .o_hold_data(w_y_hd), .o_hold_keep(w_y_hk),
    .o_hold_last(w_y_hl), .o_idle(w_y_idle)
  );

  plane_accumulator #(.OUT_W(OUT_W)) u_uv_acc (
    .clk(clk), .rst(rst), .i_mode(w_mode),
    .i_valid(uv_valid), .i_data(uv_data), .i_last(uv_last), .o_ready(uv_ready),
    .i_take(w_grant_uv),
    .o_hold_valid(w_uv_hv), .o_hold_data(w_uv_hd), .o_hold_keep(w_uv_hk),
    .o_hold_last(w_uv_hl), .o_idle(w_uv_idle)
  );

  assign w_load    = !r_out_valid || out_ready;
  assign w_contest = w_load && w_y_hv && w_uv_hv;

  always_comb begin
    w_grant_y  = 1'b0;
    w_grant_uv = 1'b0;
    if (w_contest) begin
      w_grant_uv = r_ptr_uv;
      w_grant_y  = !r_ptr_uv;
    end else if (w_load) begin
      w_grant_y  = w_y_hv;
      w_grant_uv = w_uv_hv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_uv    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_plane <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_contest) r_ptr_uv <= w_grant_y;
      if (w_load) begin
        r_out_valid <= w_grant_y || w_grant_uv;
        if (w_grant_y) begin
          r_out_data  <= w_y_hd;
          r_out_keep  <= w_y_hk;
          r_out_plane <= 1'b0;
          r_out_last  <= w_y_hl;
        end else if (w_grant_uv) begin
          r_out_data  <= w_uv_hd;
          r_out_keep  <= w_uv_hk;
          r_out_plane <= 1'b1;
          r_out_last  <= w_uv_hl;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_plane = r_out_plane;
  assign out_last  = r_out_last;

`ifdef FMT_PACKER_STATS_EN
  logic [31:0] r_y_words, r_uv_words, r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_y_words      <= '0;
      r_uv_words     <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_out_valid && out_ready && !r_out_plane) r_y_words  <= r_y_words + 32'd1;
      if (r_out_valid && out_ready && r_out_plane)  r_uv_words <= r_uv_words + 32'd1;
      if (r_out_valid && !out_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign y_words      = r_y_words;
  assign uv_words     = r_uv_words;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_multi_format_packer.sv
// Directed bench for multi_format_packer (OUT_W=64): vector table plus hand-written
// arbitration, backpressure, mode-change and reset sequences.
module tb_multi_format_packer;

  localparam int OUT_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic             y_valid, y_last, y_ready;
  logic [11:0]      y_data;
  logic             uv_valid, uv_last, uv_ready;
  logic [11:0]      uv_data;
  logic             out_valid, out_plane, out_last, out_ready;
  logic [OUT_W-1:0] out_data;
  logic [7:0]       out_keep;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_format_packer #(.OUT_W(OUT_W), .SAMPLE_W(12)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
    .uv_valid(uv_valid), .uv_data(uv_data), .uv_last(uv_last), .uv_ready(uv_ready),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_plane(out_plane), .out_last(out_last), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [1:0]        mode;
    logic              plane;
    logic [3:0]        n;
    logic              last;
    logic [7:0][11:0]  s;
    logic [63:0]       exp_data;
    logic [7:0]        exp_keep;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s timeout waiting for DUT", name);
  endtask

  // Called at a falling edge; returns at the falling edge after the sample is taken.
  task automatic push(input logic pl, input logic [11:0] d, input logic l);
    int guard = 0;
    if (!pl) begin y_valid = 1'b1; y_data = d; y_last = l; end
    else begin uv_valid = 1'b1; uv_data = d; uv_last = l; end
    while (((pl ? uv_ready : y_ready) !== 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) timeout_fail("push");
    @(negedge clk);
    y_valid = 1'b0; y_last = 1'b0; uv_valid = 1'b0; uv_last = 1'b0;
  endtask

  task automatic wait_out(input string name, output logic ok);
    int guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = (out_valid === 1'b1);
    if (!ok) timeout_fail(name);
  endtask

  task automatic expect_word(input string name, input logic [63:0] d, input logic [7:0] k,
                             input logic p, input logic l);
    logic ok;
    wait_out(name, ok);
    if (ok) begin
      chk({name, "_data"}, out_data, d);
      chk({name, "_keep"}, {56'h0, out_keep}, {56'h0, k});
      chk({name, "_plane"}, {63'h0, out_plane}, {63'h0, p});
      chk({name, "_last"}, {63'h0, out_last}, {63'h0, l});
      @(negedge clk);
    end
  endtask

  // Both planes complete a single-sample word in the same cycle.
  task automatic contest(input string name, input logic first_pl);
    logic ok;
    y_valid = 1'b1; y_data = 12'h110; y_last = 1'b1;
    uv_valid = 1'b1; uv_data = 12'h220; uv_last = 1'b1;
    @(negedge clk);
    y_valid = 1'b0; y_last = 1'b0; uv_valid = 1'b0; uv_last = 1'b0;
    wait_out(name, ok);
    if (ok) begin
      chk({name, "_first_plane"}, {63'h0, out_plane}, {63'h0, first_pl});
      chk({name, "_first_data"}, out_data, first_pl ? 64'h22 : 64'h11);
      @(negedge clk);
      chk({name, "_second_valid"}, {63'h0, out_valid}, 64'h1);
      chk({name, "_second_plane"}, {63'h0, out_plane}, {63'h0, !first_pl});
      chk({name, "_second_data"}, out_data, first_pl ? 64'h11 : 64'h22);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;

    vecs[0] = '{mode: 2'd0, plane: 1'b0, n: 4'd8, last: 1'b0,
                s: {12'h080, 12'h070, 12'h060, 12'h050, 12'h040, 12'h030, 12'h020, 12'h010},
                exp_data: 64'h0807060504030201, exp_keep: 8'hFF};
    vecs[1] = '{mode: 2'd1, plane: 1'b0, n: 4'd4, last: 1'b0,
                s: {48'h0, 12'h000, 12'h800, 12'h004, 12'hFFF},
                exp_data: 64'h0000_8000_0040_FFC0, exp_keep: 8'hFF};
    vecs[2] = '{mode: 2'd0, plane: 1'b0, n: 4'd3, last: 1'b1,
                s: {60'h0, 12'h300, 12'h200, 12'h100},
                exp_data: 64'h0000000000302010, exp_keep: 8'h07};
    vecs[3] = '{mode: 2'd2, plane: 1'b1, n: 4'd4, last: 1'b0,
                s: {48'h0, 12'h001, 12'hFFF, 12'h123, 12'hABC},
                exp_data: 64'h0010_FFF0_1230_ABC0, exp_keep: 8'hFF};
    vecs[4] = '{mode: 2'd1, plane: 1'b1, n: 4'd2, last: 1'b1,
                s: {72'h0, 12'hC03, 12'h3FF},
                exp_data: 64'h0000_0000_C000_3FC0, exp_keep: 8'h0F};
    vecs[5] = '{mode: 2'd3, plane: 1'b0, n: 4'd1, last: 1'b1,
                s: {84'h0, 12'h5A5},
                exp_data: 64'h0000_0000_0000_5A50, exp_keep: 8'h03};
    vecs[6] = '{mode: 2'd0, plane: 1'b1, n: 4'd8, last: 1'b0,
                s: {12'h9A0, 12'h780, 12'h560, 12'h340, 12'h120, 12'hAB0, 12'h000, 12'hFF0},
                exp_data: 64'h9A78563412AB00FF, exp_keep: 8'hFF};

    // Reset
    rst = 1'b1; mode = 2'd0; out_ready = 1'b1;
    y_valid = 1'b0; y_data = '0; y_last = 1'b0;
    uv_valid = 1'b0; uv_data = '0; uv_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_keep", {56'h0, out_keep}, 64'h0);
    chk("rst_out_plane", {63'h0, out_plane}, 64'h0);
    chk("rst_out_last", {63'h0, out_last}, 64'h0);
    chk("rst_y_ready", {63'h0, y_ready}, 64'h1);
    chk("rst_uv_ready", {63'h0, uv_ready}, 64'h1);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].mode;
      for (int k = 0; k < int'(vecs[i].n); k++)
        push(vecs[i].plane, vecs[i].s[k], vecs[i].last && (k == int'(vecs[i].n) - 1));
      expect_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_keep,
                  vecs[i].plane, vecs[i].last);
    end

    // Round-robin: Y wins the first contest, then contests alternate
    mode = 2'd0;
    @(negedge clk);
    contest("arb1", 1'b0);
    contest("arb2", 1'b1);
    contest("arb3", 1'b0);

    // Backpressure: two words fit (output register + hold), then Y stalls
    out_ready = 1'b0;
    cnt = 0;
    y_valid = 1'b1; y_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      y_data = 12'((cnt + 1) << 4);
      if (y_ready === 1'b1) cnt++;
      @(negedge clk);
    end
    y_valid = 1'b0;
    chk("bp_accepted", 64'(cnt), 64'd16);
    chk("bp_y_ready_low", {63'h0, y_ready}, 64'h0);
    chk("bp_held_valid", {63'h0, out_valid}, 64'h1);
    chk("bp_held_data", out_data, 64'h0807060504030201);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_word2_valid", {63'h0, out_valid}, 64'h1);
    chk("bp_word2_data", out_data, 64'h100F0E0D0C0B0A09);
    @(negedge clk);
    chk("bp_drained", {63'h0, out_valid}, 64'h0);

    // Mode change mid-word stays NV12 until the packer is idle
    mode = 2'd0;
    push(1'b0, 12'h010, 1'b0);
    push(1'b0, 12'h020, 1'b0);
    mode = 2'd1;
    for (int k = 3; k <= 8; k++) push(1'b0, 12'(k << 4), 1'b0);
    expect_word("mchg_old", 64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
    push(1'b0, 12'hFFF, 1'b0);
    push(1'b0, 12'h004, 1'b0);
    push(1'b0, 12'h800, 1'b0);
    push(1'b0, 12'h000, 1'b0);
    expect_word("mchg_new", 64'h0000_8000_0040_FFC0, 8'hFF, 1'b0, 1'b0);

    // Reset mid-word discards the partial accumulation
    mode = 2'd0;
    @(negedge clk);
    push(1'b0, 12'h100, 1'b0);
    push(1'b0, 12'h200, 1'b0);
    push(1'b0, 12'h300, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("midrst_y_ready", {63'h0, y_ready}, 64'h1);
    push(1'b0, 12'h0A0, 1'b1);
    expect_word("midrst_word", 64'h000000000000000A, 8'h01, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
